fb_writer: RTL and testbench
============================

FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter H_RES, default 320: frame buffer width in pixels.
REQ-002 Parameter V_RES, default 240: frame buffer height in pixels.
REQ-003 clk  input  1  single clock, which is also the frame buffer port-A write clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  2  opcode: 00 pixel, 01 fill rectangle, 10 clear screen, 11 reserved.
REQ-008 cmd_x0, cmd_x1  input  9  column coordinates.
REQ-009 cmd_y0, cmd_y1  input  8  row coordinates.
REQ-010 cmd_color  input  12  RGB444 pixel value {R,G,B}.
REQ-011 wea  output  1  frame buffer write enable.
REQ-012 addra  output  17  frame buffer write address.
REQ-013 dina  output  12  frame buffer write data.
REQ-014 busy  output  1  a command is in progress.
REQ-015 done  output  1  one-cycle pulse on command completion.

Function
REQ-016 The block SHALL use the states IDLE, PIX, FILL and FIN.
- cmd_ready = 1 only in IDLE.
- busy = 1 in PIX, FILL and FIN.
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
- All cmd_* fields are captured on that edge.
- Input changes after acceptance have no effect until the next acceptance.
REQ-018 Pixel address SHALL be y*H_RES + x, computed without a multiplier.
- A row-base register adds H_RES per row.
- A column offset adds 1 per pixel.
REQ-019 wea, addra and dina SHALL be registered outputs.
- wea = 1 exactly in cycles carrying a valid write.
- addra and dina hold their last values when wea = 0.
REQ-020 Pixel (op 00), in range (x0 < H_RES and y0 < V_RES):
- IDLE -> PIX on acceptance.
- In the cycle after acceptance: wea = 1, addra = y0*H_RES + x0, dina = cmd_color.
- PIX -> FIN.
REQ-021 Pixel (op 00), out of range: the block SHALL go IDLE -> FIN with no write.
REQ-022 Fill (op 01):
- x1 is clamped to H_RES-1 and y1 to V_RES-1 at acceptance.
- If x0 > clamped x1, x0 >= H_RES, y0 > clamped y1, or y0 >= V_RES, go IDLE -> FIN with no write.
- Otherwise IDLE -> FILL, writing one pixel per cycle in raster order: x0..x1 within each row, rows y0..y1.
REQ-023 In FILL, the first write SHALL occur in the cycle after acceptance.
- Writes are continuous with no gap cycles, including across row boundaries.
- FILL -> FIN after the write of (x1,y1).
REQ-024 Clear (op 10) SHALL behave as a fill of (0,0)-(H_RES-1,V_RES-1) with cmd_color, ignoring coordinate inputs (76800 writes at default parameters).
REQ-025 Reserved op 11 SHALL be accepted and go IDLE -> FIN with no write.
REQ-026 In FIN, done = 1 for exactly one cycle, then FIN -> IDLE.
- A new command is accepted no earlier than the cycle after done.
- No write occurs in FIN.
REQ-027 Latency from acceptance edge to done for an N-pixel command (N >= 1) SHALL be N+1 cycles; for a zero-write command it SHALL be 1 cycle.
REQ-028 cmd_valid asserted while cmd_ready = 0 SHALL be ignored; the requester holds it until accepted.
REQ-029 The last address written SHALL never exceed H_RES*V_RES-1 (76799).
- Counters are wide enough that the column, row and address arithmetic never wraps.

Reset
REQ-030 While rst = 1, the block SHALL be forced asynchronously to:
- state IDLE, cmd_ready = 1, busy = 0, done = 0;
- wea = 0, addra = 0, dina = 0;
- all counters 0.
REQ-031 Reset asserted mid-command SHALL abort the command immediately.
- No further write occurs.
- No done pulse is issued.
- The first command after deassertion is processed normally.

Verification
REQ-032 Pixel write: op 00, x0=5, y0=2, color 12'hF00 -> one cycle later wea=1, addra=645, dina=12'hF00; done one cycle after that; total of 1 write.
REQ-033 Out-of-range pixel: op 00, x0=320, y0=0 -> no wea; done 1 cycle after acceptance.
REQ-034 Fill with clamp: op 01, (318,1)-(400,2), color 12'h0F0 -> 4 consecutive writes at addresses 638, 639, 958, 959; done at cycle 5 after acceptance.
REQ-035 Clear: op 10, color 12'h000 -> 76800 consecutive writes with addresses 0..76799 strictly incrementing; done at cycle 76801; busy high throughout.
REQ-036 Degenerate and reserved ops: op 01 with x0=10, x1=9, and op 11 -> no writes; done 1 cycle after each acceptance; cmd_valid held high during busy is not accepted a second time.
REQ-037 Reset mid-fill: assert rst after the 3rd write of a 10x10 fill -> wea=0 immediately, cmd_ready=1 and no done pulse; a subsequent pixel command completes per REQ-020.

Source files
------------

// File: rtl/fb_writer.sv
// Frame buffer writer: turns pixel, rectangle-fill and clear-screen commands
// into a stream of single-pixel writes on a dual-port RAM write port.
// Addresses are formed as row_base + column; row_base steps by H_RES per row.
module fb_writer #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_x0,
    input  logic [8:0]  cmd_x1,
    input  logic [7:0]  cmd_y0,
    input  logic [7:0]  cmd_y1,
    input  logic [11:0] cmd_color,
    output logic        wea,
    output logic [16:0] addra,
    output logic [11:0] dina,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0]  X_MAX  = 9'(H_RES - 1);
    localparam logic [7:0]  Y_MAX  = 8'(V_RES - 1);
    localparam logic [16:0] H_STEP = 17'(H_RES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIX  = 2'd1,
        FILL = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_r;
    logic [8:0]  col_r;
    logic [7:0]  row_r;
    logic [8:0]  x0_r;
    logic [8:0]  x1_r;
    logic [7:0]  y1_r;
    logic [16:0] base_r;

    logic [8:0]  sx0_s;
    logic [8:0]  sx1_s;
    logic [7:0]  sy0_s;
    logic [7:0]  sy1_s;
    logic        is_write_s;
    logic        is_fill_s;
    logic [16:0] start_base_s;
    logic [16:0] start_addr_s;
    logic        last_s;
    logic [16:0] next_base_s;

    // Constant-coefficient shift-add: y * H_RES built from the set bits of y.
    function automatic logic [16:0] row_base(input logic [7:0] y);
        logic [16:0] acc;
        acc = 17'd0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                acc = acc + (H_STEP << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Decode the incoming command into a clamped rectangle and a write/no-write verdict.
    always_comb begin
        sx0_s      = cmd_x0;
        sy0_s      = cmd_y0;
        sx1_s      = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        sy1_s      = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        is_write_s = 1'b0;
        is_fill_s  = 1'b0;
        case (cmd_op)
            2'b00: begin
                is_write_s = (cmd_x0 <= X_MAX) && (cmd_y0 <= Y_MAX);
            end
            2'b01: begin
                is_fill_s  = 1'b1;
                is_write_s = (cmd_x0 <= X_MAX) && (cmd_y0 <= Y_MAX) &&
                             (cmd_x0 <= sx1_s) && (cmd_y0 <= sy1_s);
            end
            2'b10: begin
                is_fill_s  = 1'b1;
                is_write_s = 1'b1;
                sx0_s      = 9'd0;
                sx1_s      = X_MAX;
                sy0_s      = 8'd0;
                sy1_s      = Y_MAX;
            end
            default: begin
                is_write_s = 1'b0;
            end
        endcase
    end

    assign start_base_s = row_base(sy0_s);
    assign start_addr_s = start_base_s + {8'd0, sx0_s};
    assign last_s       = (col_r == x1_r) && (row_r == y1_r);
    assign next_base_s  = base_r + H_STEP;

    // Command sequencer: accepts commands, walks the rectangle, drives registered RAM port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wea       <= 1'b0;
            addra     <= 17'd0;
            dina      <= 12'd0;
            col_r     <= 9'd0;
            row_r     <= 8'd0;
            x0_r      <= 9'd0;
            x1_r      <= 9'd0;
            y1_r      <= 8'd0;
            base_r    <= 17'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    wea  <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (is_write_s) begin
                            wea     <= 1'b1;
                            addra   <= start_addr_s;
                            dina    <= cmd_color;
                            col_r   <= sx0_s;
                            row_r   <= sy0_s;
                            x0_r    <= sx0_s;
                            x1_r    <= sx1_s;
                            y1_r    <= sy1_s;
                            base_r  <= start_base_s;
                            state_r <= is_fill_s ? FILL : PIX;
                        end else begin
                            done    <= 1'b1;
                            state_r <= FIN;
                        end
                    end
                end
                PIX: begin
                    wea     <= 1'b0;
                    done    <= 1'b1;
                    state_r <= FIN;
                end
                FILL: begin
                    if (last_s) begin
                        wea     <= 1'b0;
                        done    <= 1'b1;
                        state_r <= FIN;
                    end else if (col_r == x1_r) begin
                        // Row wrap: next write is the first column of the next row.
                        wea    <= 1'b1;
                        col_r  <= x0_r;
                        row_r  <= row_r + 8'd1;
                        base_r <= next_base_s;
                        addra  <= next_base_s + {8'd0, x0_r};
                    end else begin
                        wea   <= 1'b1;
                        col_r <= col_r + 9'd1;
                        addra <= base_r + {8'd0, col_r} + 17'd1;
                    end
                end
                FIN: begin
                    wea       <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    wea       <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed vector table, reset corner case,
// and random commands compared against a plain-arithmetic pixel-list model.
module tb_fb_writer;

    localparam int H = 320;
    localparam int V = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_x0, cmd_x1;
    logic [7:0]  cmd_y0, cmd_y1;
    logic [11:0] cmd_color;
    logic        wea;
    logic [16:0] addra;
    logic [11:0] dina;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int got_q[$];

    fb_writer #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0),
        .cmd_y1(cmd_y1), .cmd_color(cmd_color), .wea(wea), .addra(addra),
        .dina(dina), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op; int x0; int x1; int y0; int y1; int color; bit hold;
        int exp_n; int exp_first; int exp_last; int exp_lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list every pixel address the command should touch, in raster order.
    task automatic build_model(input int op, input int x0, input int x1,
                               input int y0, input int y1);
        int cx1, cy1;
        exp_q.delete();
        cx1 = (x1 > H - 1) ? H - 1 : x1;
        cy1 = (y1 > V - 1) ? V - 1 : y1;
        if (op == 0) begin
            if (x0 < H && y0 < V) exp_q.push_back(y0 * H + x0);
        end else if (op == 1) begin
            if (x0 < H && y0 < V && x0 <= cx1 && y0 <= cy1)
                for (int y = y0; y <= cy1; y++)
                    for (int x = x0; x <= cx1; x++)
                        exp_q.push_back(y * H + x);
        end else if (op == 2) begin
            for (int a = 0; a < H * V; a++) exp_q.push_back(a);
        end
    endtask

    task automatic run_cmd(input string tag, input int op, input int x0, input int x1,
                           input int y0, input int y1, input int color, input bit hold,
                           output int lat, output int nw, output int first, output int last);
        int w, busy_bad, dina_bad, bad_idx, extra, exp_lat, budget;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".ready"}, int'(cmd_ready), 1);
        cmd_op = 2'(op); cmd_x0 = 9'(x0); cmd_x1 = 9'(x1);
        cmd_y0 = 8'(y0); cmd_y1 = 8'(y1); cmd_color = 12'(color);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_x0 = 9'($urandom); cmd_x1 = 9'($urandom);
        cmd_y0 = 8'($urandom); cmd_y1 = 8'($urandom); cmd_color = 12'($urandom);
        build_model(op, x0, x1, y0, y1);
        exp_lat = (exp_q.size() == 0) ? 1 : exp_q.size() + 1;
        budget = exp_q.size() + 10;
        got_q.delete();
        lat = -1; busy_bad = 0; dina_bad = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (wea === 1'b1) begin
                got_q.push_back(int'(addra));
                if (dina !== 12'(color)) dina_bad++;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".nwrites"}, got_q.size(), exp_q.size());
        check({tag, ".busy_low_cycles"}, busy_bad, 0);
        check({tag, ".bad_dina_cycles"}, dina_bad, 0);
        bad_idx = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) begin
                bad_idx = i;
                break;
            end
        n_checks++;
        if (bad_idx >= 0) begin
            n_fail++;
            $display("FAIL %s.addr_seq[%0d]: got %0d expected %0d",
                     tag, bad_idx, got_q[bad_idx], exp_q[bad_idx]);
        end
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wea === 1'b1 || done === 1'b1) extra++;
        end
        check({tag, ".quiet_after_done"}, extra, 0);
        check({tag, ".ready_after"}, int'(cmd_ready), 1);
        nw = got_q.size();
        first = (nw > 0) ? got_q[0] : -1;
        last = (nw > 0) ? got_q[nw - 1] : -1;
    endtask

    initial begin
        vec_t vecs[8];
        int lat, nw, first, last, writes, extra;
        int op, x0, x1, y0, y1;

        vecs[0] = '{0, 5,   0,   2,   0, 12'hF00, 1'b0, 1,     645,   645,   2};
        vecs[1] = '{0, 320, 0,   0,   0, 12'h123, 1'b0, 0,     -1,    -1,    1};
        vecs[2] = '{1, 318, 400, 1,   2, 12'h0F0, 1'b0, 4,     638,   959,   5};
        vecs[3] = '{1, 10,  9,   0,   0, 12'h456, 1'b1, 0,     -1,    -1,    1};
        vecs[4] = '{3, 0,   5,   0,   5, 12'h789, 1'b1, 0,     -1,    -1,    1};
        vecs[5] = '{2, 7,   3,   9,   1, 12'h000, 1'b0, 76800, 0,     76799, 76801};
        vecs[6] = '{0, 319, 0,   239, 0, 12'hABC, 1'b0, 1,     76799, 76799, 2};
        vecs[7] = '{0, 0,   0,   240, 0, 12'hDEF, 1'b0, 0,     -1,    -1,    1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
        cmd_x0 = 9'd0; cmd_x1 = 9'd0; cmd_y0 = 8'd0; cmd_y1 = 8'd0; cmd_color = 12'd0;
        repeat (3) @(negedge clk);
        check("reset.cmd_ready", int'(cmd_ready), 1);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.wea", int'(wea), 0);
        check("reset.addra", int'(addra), 0);
        check("reset.dina", int'(dina), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_cmd(t, vecs[i].op, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1,
                    vecs[i].color, vecs[i].hold, lat, nw, first, last);
            check({t, ".tbl_n"}, nw, vecs[i].exp_n);
            check({t, ".tbl_lat"}, lat, vecs[i].exp_lat);
            if (vecs[i].exp_n > 0) begin
                check({t, ".tbl_first"}, first, vecs[i].exp_first);
                check({t, ".tbl_last"}, last, vecs[i].exp_last);
            end
        end

        // Reset in the middle of a 10x10 fill, after its third write.
        cmd_op = 2'd1; cmd_x0 = 9'd0; cmd_x1 = 9'd9; cmd_y0 = 8'd0; cmd_y1 = 8'd9;
        cmd_color = 12'h321; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        writes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wea === 1'b1) writes++;
            if (writes == 3) break;
        end
        check("midrst.writes_before", writes, 3);
        #1;
        rst = 1'b1;
        #1;
        check("midrst.wea", int'(wea), 0);
        check("midrst.cmd_ready", int'(cmd_ready), 1);
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.addra", int'(addra), 0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wea === 1'b1 || done === 1'b1) extra++;
        end
        check("midrst.quiet", extra, 0);
        run_cmd("after_rst", 0, 7, 0, 3, 0, 12'h5A5, 1'b0, lat, nw, first, last);
        check("after_rst.addr", first, 967);

        for (int i = 0; i < 25; i++) begin
            op = int'($urandom_range(0, 3));
            if (op == 2) op = 1;
            x0 = int'($urandom_range(0, 329));
            x1 = x0 + int'($urandom_range(0, 5)) - 1;
            if (x1 < 0) x1 = 0;
            y0 = int'($urandom_range(0, 245));
            y1 = y0 + int'($urandom_range(0, 3)) - 1;
            if (y1 < 0) y1 = 0;
            if (y1 > 255) y1 = 255;
            run_cmd($sformatf("rnd%0d", i), op, x0, x1, y0, y1,
                    int'($urandom_range(0, 4095)), 1'($urandom), lat, nw, first, last);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
